// File: rtl/icache_nb_ctrl.sv
// Non-blocking instruction cache miss controller.
// Tracks outstanding line fetches in a small MSHR file and drives cache fills.
module icache_nb_ctrl #(
  parameter int WAYS       = 3,
  parameter int XLEN       = 32,
  parameter int IDX_W      = 5,
  parameter int MSHR_DEPTH = 4,
  parameter int MTAG_W     = 4,
  localparam int TAG_BITS  = XLEN - 3 - IDX_W,
  localparam int CNT_W     = $clog2(MSHR_DEPTH + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   take_branch,
  input  logic                   hit_but_stall,
  input  logic [WAYS*XLEN-1:0]   proc2Icache_addr,
  input  logic [WAYS*64-1:0]     cachemem_data,
  input  logic [WAYS-1:0]        cachemem_valid,
  input  logic [MTAG_W-1:0]      Imem2proc_response,
  input  logic [MTAG_W-1:0]      Imem2proc_tag,
  input  logic [63:0]            Imem2proc_data,
  output logic [1:0]             proc2Imem_command,
  output logic [XLEN-1:0]        proc2Imem_addr,
  output logic [WAYS*32-1:0]     Icache_data_out,
  output logic [WAYS-1:0]        Icache_valid_out,
  output logic                   wr_en,
  output logic [IDX_W-1:0]       wr_idx,
  output logic [TAG_BITS-1:0]    wr_tag,
  output logic [63:0]            wr_data,
  output logic                   mshr_full,
  output logic [CNT_W-1:0]       mshr_count
);

  localparam int BLK_W = XLEN - 3;
  localparam int SEL_W = (MSHR_DEPTH > 1) ? $clog2(MSHR_DEPTH) : 1;
  localparam logic [1:0] BUS_NONE = 2'd0;
  localparam logic [1:0] BUS_LOAD = 2'd1;

  logic [MSHR_DEPTH-1:0] vld_q;
  logic [MSHR_DEPTH-1:0] vld_d;
  logic [BLK_W-1:0]      blk_q  [MSHR_DEPTH];
  logic [MTAG_W-1:0]     mtag_q [MSHR_DEPTH];

  logic             cand_found;
  logic             cand_ok;
  logic [BLK_W-1:0] cand_blk;
  logic             dup;
  logic             issue;
  logic             accept;
  logic [SEL_W-1:0] free_sel;
  logic             fill_hit;
  logic [SEL_W-1:0] fill_sel;
  logic [BLK_W-1:0] fill_blk;
  logic [CNT_W-1:0] cnt;
  logic             unused_addr_lo;

  always_comb begin
    Icache_data_out = '0;
    for (int i = 0; i < WAYS; i++) begin
      Icache_data_out[i*32 +: 32] = proc2Icache_addr[i*XLEN + 2]
        ? cachemem_data[i*64 + 32 +: 32]
        : cachemem_data[i*64 +: 32];
    end
  end

  assign Icache_valid_out = cachemem_valid;

  always_comb begin
    unused_addr_lo = 1'b0;
    for (int i = 0; i < WAYS; i++) begin
      unused_addr_lo = unused_addr_lo ^ (^proc2Icache_addr[i*XLEN +: 2]);
    end
  end

  // Lowest-index missing way is the only one serviced per cycle.
  always_comb begin
    cand_found = 1'b0;
    cand_blk   = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!cachemem_valid[i]) begin
        cand_found = 1'b1;
        cand_blk   = proc2Icache_addr[i*XLEN + 3 +: BLK_W];
      end
    end
  end

  assign cand_ok = cand_found && !hit_but_stall;

  always_comb begin
    dup      = 1'b0;
    free_sel = '0;
    fill_hit = 1'b0;
    fill_sel = '0;
    fill_blk = '0;
    cnt      = '0;
    for (int e = MSHR_DEPTH - 1; e >= 0; e--) begin
      if (vld_q[e] && blk_q[e] == cand_blk) begin
        dup = 1'b1;
      end
      if (!vld_q[e]) begin
        free_sel = SEL_W'(e);
      end
      if (vld_q[e] && Imem2proc_tag != '0 && mtag_q[e] == Imem2proc_tag) begin
        fill_hit = 1'b1;
        fill_sel = SEL_W'(e);
        fill_blk = blk_q[e];
      end
      cnt = cnt + CNT_W'(vld_q[e]);
    end
  end

  assign mshr_full  = &vld_q;
  assign mshr_count = cnt;

  assign issue  = cand_ok && !dup && !mshr_full && !take_branch && !reset;
  assign accept = issue && (Imem2proc_response != '0);

  assign proc2Imem_command = issue ? BUS_LOAD : BUS_NONE;
  assign proc2Imem_addr    = issue ? {cand_blk, 3'b000} : '0;

  assign wr_en   = fill_hit && !reset;
  assign wr_idx  = fill_blk[IDX_W-1:0];
  assign wr_tag  = fill_blk[BLK_W-1:IDX_W];
  assign wr_data = Imem2proc_data;

  // Fill frees a valid slot, accept claims a free one: never the same entry.
  always_comb begin
    vld_d = vld_q;
    if (fill_hit) begin
      vld_d[fill_sel] = 1'b0;
    end
    if (accept) begin
      vld_d[free_sel] = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
      for (int e = 0; e < MSHR_DEPTH; e++) begin
        blk_q[e]  <= '0;
        mtag_q[e] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      if (accept) begin
        blk_q[free_sel]  <= cand_blk;
        mtag_q[free_sel] <= Imem2proc_response;
      end
    end
  end

endmodule

// File: tb/tb_icache_nb_ctrl.sv
// Directed bench for icache_nb_ctrl: miss issue, dedup, full, retry,
// branch/stall suppression and reset mid-flight.
module tb_icache_nb_ctrl;

  localparam int WAYS = 3;
  localparam int XLEN = 32;

  logic                 clock;
  logic                 reset;
  logic                 take_branch;
  logic                 hit_but_stall;
  logic [WAYS*XLEN-1:0] proc2Icache_addr;
  logic [WAYS*64-1:0]   cachemem_data;
  logic [WAYS-1:0]      cachemem_valid;
  logic [3:0]           Imem2proc_response;
  logic [3:0]           Imem2proc_tag;
  logic [63:0]          Imem2proc_data;
  logic [1:0]           proc2Imem_command;
  logic [XLEN-1:0]      proc2Imem_addr;
  logic [WAYS*32-1:0]   Icache_data_out;
  logic [WAYS-1:0]      Icache_valid_out;
  logic                 wr_en;
  logic [4:0]           wr_idx;
  logic [23:0]          wr_tag;
  logic [63:0]          wr_data;
  logic                 mshr_full;
  logic [2:0]           mshr_count;

  int total;
  int bad;
  int issues;

  icache_nb_ctrl dut (
    .clock              (clock),
    .reset              (reset),
    .take_branch        (take_branch),
    .hit_but_stall      (hit_but_stall),
    .proc2Icache_addr   (proc2Icache_addr),
    .cachemem_data      (cachemem_data),
    .cachemem_valid     (cachemem_valid),
    .Imem2proc_response (Imem2proc_response),
    .Imem2proc_tag      (Imem2proc_tag),
    .Imem2proc_data     (Imem2proc_data),
    .proc2Imem_command  (proc2Imem_command),
    .proc2Imem_addr     (proc2Imem_addr),
    .Icache_data_out    (Icache_data_out),
    .Icache_valid_out   (Icache_valid_out),
    .wr_en              (wr_en),
    .wr_idx             (wr_idx),
    .wr_tag             (wr_tag),
    .wr_data            (wr_data),
    .mshr_full          (mshr_full),
    .mshr_count         (mshr_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    take_branch        = 1'b0;
    hit_but_stall      = 1'b0;
    cachemem_valid     = '1;
    Imem2proc_response = '0;
    Imem2proc_tag      = '0;
    Imem2proc_data     = '0;
  endtask

  task automatic set_miss(input int way, input logic [31:0] a);
    cachemem_valid = '1;
    cachemem_valid[way] = 1'b0;
    proc2Icache_addr[way*XLEN +: XLEN] = a;
  endtask

  initial begin
    total = 0;
    bad = 0;
    proc2Icache_addr = '0;
    cachemem_data = '0;
    idle();
    reset = 1'b1;
    set_miss(0, 32'h0000_1004);
    Imem2proc_response = 4'd1;
    #2;
    chk("rst_cmd", 64'(proc2Imem_command), 64'd0);
    chk("rst_addr", 64'(proc2Imem_addr), 64'd0);
    chk("rst_cnt", 64'(mshr_count), 64'd0);
    chk("rst_full", 64'(mshr_full), 64'd0);
    chk("rst_wren", 64'(wr_en), 64'd0);

    nxt();
    reset = 1'b0;
    idle();
    proc2Icache_addr[0 +: 32] = 32'h0000_0104;
    proc2Icache_addr[32 +: 32] = 32'h0000_0200;
    cachemem_data[0 +: 64] = 64'h1111_2222_3333_4444;
    cachemem_data[64 +: 64] = 64'h5555_6666_7777_8888;
    cachemem_valid = 3'b101;
    hit_but_stall = 1'b1;
    #1;
    chk("dout0", 64'(Icache_data_out[0 +: 32]), 64'h1111_2222);
    chk("dout1", 64'(Icache_data_out[32 +: 32]), 64'h7777_8888);
    chk("vout", 64'(Icache_valid_out), 64'h5);
    chk("stall_cmd0", 64'(proc2Imem_command), 64'd0);

    // single miss
    nxt();
    idle();
    set_miss(0, 32'h0000_1004);
    Imem2proc_response = 4'd3;
    #1;
    chk("sm_cmd", 64'(proc2Imem_command), 64'd1);
    chk("sm_addr", 64'(proc2Imem_addr), 64'h1000);
    nxt();
    Imem2proc_response = 4'd0;
    #1;
    chk("sm_cnt1", 64'(mshr_count), 64'd1);
    chk("sm_dup", 64'(proc2Imem_command), 64'd0);
    nxt();
    idle();
    Imem2proc_tag = 4'd3;
    Imem2proc_data = 64'hDEAD_BEEF_CAFE_F00D;
    #1;
    chk("sm_wren", 64'(wr_en), 64'd1);
    chk("sm_widx", 64'(wr_idx), 64'h00);
    chk("sm_wtag", 64'(wr_tag), 64'h010);
    chk("sm_wdata", wr_data, 64'hDEAD_BEEF_CAFE_F00D);
    nxt();
    idle();
    #1;
    chk("sm_cnt0", 64'(mshr_count), 64'd0);
    chk("sm_wren0", 64'(wr_en), 64'd0);

    // dedup across ways
    issues = 0;
    for (int c = 0; c < 4; c++) begin
      nxt();
      idle();
      cachemem_valid = 3'b100;
      proc2Icache_addr[0 +: 32] = 32'h0000_1000;
      proc2Icache_addr[32 +: 32] = 32'h0000_1004;
      Imem2proc_response = 4'd5;
      #1;
      if (proc2Imem_command == 2'd1) issues++;
    end
    chk("dd_issues", 64'(issues), 64'd1);
    chk("dd_cnt", 64'(mshr_count), 64'd1);
    nxt();
    idle();
    Imem2proc_tag = 4'd5;
    #1;
    chk("dd_wren", 64'(wr_en), 64'd1);
    nxt();
    idle();
    #1;
    chk("dd_cnt0", 64'(mshr_count), 64'd0);

    // fill the MSHR file
    for (int k = 0; k < 4; k++) begin
      nxt();
      idle();
      set_miss(0, 32'h0000_2000 + 32'(k) * 32'h1000);
      Imem2proc_response = 4'(k + 1);
      #1;
      chk("fl_cmd", 64'(proc2Imem_command), 64'd1);
    end
    nxt();
    idle();
    set_miss(0, 32'h0000_6000);
    Imem2proc_response = 4'd7;
    #1;
    chk("fl_full", 64'(mshr_full), 64'd1);
    chk("fl_cnt4", 64'(mshr_count), 64'd4);
    chk("fl_none", 64'(proc2Imem_command), 64'd0);
    nxt();
    Imem2proc_tag = 4'd2;
    #1;
    chk("fl_samecyc", 64'(proc2Imem_command), 64'd0);
    chk("fl_wren", 64'(wr_en), 64'd1);
    chk("fl_wtag", 64'(wr_tag), 64'h30);
    nxt();
    Imem2proc_tag = 4'd0;
    #1;
    chk("fl_cnt3", 64'(mshr_count), 64'd3);
    chk("fl_reiss", 64'(proc2Imem_command), 64'd1);
    chk("fl_raddr", 64'(proc2Imem_addr), 64'h6000);
    nxt();
    idle();
    #1;
    chk("fl_full2", 64'(mshr_full), 64'd1);
    for (int k = 0; k < 4; k++) begin
      nxt();
      idle();
      case (k)
        0: Imem2proc_tag = 4'd1;
        1: Imem2proc_tag = 4'd3;
        2: Imem2proc_tag = 4'd4;
        default: Imem2proc_tag = 4'd7;
      endcase
      #1;
      chk("fl_drain", 64'(wr_en), 64'd1);
      if (k == 3) chk("fl_tag6", 64'(wr_tag), 64'h60);
    end
    nxt();
    idle();
    #1;
    chk("fl_cnt0", 64'(mshr_count), 64'd0);

    // reject then retry
    issues = 0;
    for (int c = 0; c < 3; c++) begin
      nxt();
      idle();
      set_miss(2, 32'h0000_7008);
      Imem2proc_response = (c == 2) ? 4'd5 : 4'd0;
      #1;
      if (proc2Imem_command == 2'd1) issues++;
      if (c == 1) chk("rj_cnt0", 64'(mshr_count), 64'd0);
    end
    nxt();
    idle();
    #1;
    chk("rj_issues", 64'(issues), 64'd3);
    chk("rj_cnt1", 64'(mshr_count), 64'd1);
    nxt();
    idle();
    Imem2proc_tag = 4'd5;
    #1;
    chk("rj_widx", 64'(wr_idx), 64'h01);
    chk("rj_wtag", 64'(wr_tag), 64'h70);

    // branch and stall
    nxt();
    idle();
    set_miss(0, 32'h0000_8000);
    Imem2proc_response = 4'd6;
    #1;
    chk("br_alloc", 64'(proc2Imem_command), 64'd1);
    nxt();
    idle();
    set_miss(0, 32'h0000_9000);
    take_branch = 1'b1;
    Imem2proc_response = 4'd9;
    Imem2proc_tag = 4'd6;
    #1;
    chk("br_cmd", 64'(proc2Imem_command), 64'd0);
    chk("br_wren", 64'(wr_en), 64'd1);
    chk("br_wtag", 64'(wr_tag), 64'h80);
    nxt();
    idle();
    set_miss(0, 32'h0000_9000);
    hit_but_stall = 1'b1;
    #1;
    chk("st_cmd", 64'(proc2Imem_command), 64'd0);
    chk("st_cnt", 64'(mshr_count), 64'd0);
    nxt();
    hit_but_stall = 1'b0;
    #1;
    chk("st_rel", 64'(proc2Imem_command), 64'd1);

    // reset mid-flight
    nxt();
    idle();
    set_miss(0, 32'h0000_A000);
    Imem2proc_response = 4'd8;
    #1;
    nxt();
    idle();
    set_miss(1, 32'h0000_B000);
    Imem2proc_response = 4'd9;
    #1;
    nxt();
    idle();
    #1;
    chk("mr_cnt2", 64'(mshr_count), 64'd2);
    reset = 1'b1;
    set_miss(0, 32'h0000_C000);
    Imem2proc_response = 4'd1;
    #1;
    chk("mr_cnt0", 64'(mshr_count), 64'd0);
    chk("mr_cmd", 64'(proc2Imem_command), 64'd0);
    nxt();
    reset = 1'b0;
    idle();
    Imem2proc_tag = 4'd8;
    #1;
    chk("mr_oldtag", 64'(wr_en), 64'd0);
    chk("mr_cnt", 64'(mshr_count), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/icache_nb_ctrl.md
ICACHE_NB_CTRL -- requirements
Module: icache_nb_ctrl

Interface
REQ-001 SHALL have parameter WAYS, default 3, fetch addresses looked up per cycle.
REQ-002 SHALL have parameter XLEN, default 32, address width.
REQ-003 SHALL have parameter IDX_W, default 5, cache index width; tag width TAG_BITS = XLEN-3-IDX_W.
REQ-004 SHALL have parameter MSHR_DEPTH, default 4, maximum outstanding misses (>=1).
REQ-005 SHALL have parameter MTAG_W, default 4, memory transaction tag width; tag 0 means none.
REQ-006 SHALL have one clock and an asynchronous, active-high reset. The ports are named clock and reset.
REQ-007 clock  in  1  rising-edge clock.
REQ-008 reset  in  1  asynchronous active-high reset.
REQ-009 take_branch  in  1  redirect this cycle.
REQ-010 hit_but_stall  in  1  fetch stalled; suppress miss handling.
REQ-011 proc2Icache_addr  in  WAYS*XLEN  fetch address per way.
REQ-012 cachemem_data  in  WAYS*64  cache line read per way.
REQ-013 cachemem_valid  in  WAYS  cache hit per way.
REQ-014 Imem2proc_response  in  MTAG_W  tag accepted for the current request (0 = rejected).
REQ-015 Imem2proc_tag  in  MTAG_W  tag of the returning fill (0 = none).
REQ-016 Imem2proc_data  in  64  fill data.
REQ-017 proc2Imem_command  out  2  BUS_NONE or BUS_LOAD.
REQ-018 proc2Imem_addr  out  XLEN  8-byte-aligned request address, 0 when idle.
REQ-019 Icache_data_out  out  WAYS*32  selected instruction word per way.
REQ-020 Icache_valid_out  out  WAYS  equals cachemem_valid.
REQ-021 wr_en / wr_idx / wr_tag / wr_data  out  1 / IDX_W / TAG_BITS / 64  cache fill write port.
REQ-022 mshr_full  out  1  all MSHR entries valid (registered state).
REQ-023 mshr_count  out  clog2(MSHR_DEPTH+1)  valid entry count.

Function
REQ-024 Address split: idx = addr[IDX_W+2:3]; tag = addr[XLEN-1:IDX_W+3]; Icache_data_out[i] = addr[2] ? data[63:32] : data[31:0].
REQ-025 Each MSHR entry holds valid, block address addr[XLEN-1:3] and memory tag.
REQ-026 Miss candidate: the lowest-index way with cachemem_valid=0. There is no candidate when hit_but_stall=1.
REQ-027 Duplicate: the candidate block equals any valid entry block, or equals the block being filled this cycle. A duplicate issues no request.
REQ-028 Issue: proc2Imem_command=BUS_LOAD, combinationally, only if all of the following hold: a candidate exists, it is not a duplicate, mshr_full=0, take_branch=0 and reset=0. Otherwise BUS_NONE. proc2Imem_addr = {block,3'b0} while issuing, else 0.
REQ-029 Accept: when issuing with Imem2proc_response!=0, the lowest-index free entry is loaded at the next edge with {block, response}.
REQ-030 Reject: when issuing with response==0, no state changes. The request re-presents on the next cycle if its conditions still hold.
REQ-031 Fill: when Imem2proc_tag!=0 matches a valid entry's tag, wr_en=1 in the same cycle, with wr_idx/wr_tag taken from that entry and wr_data=Imem2proc_data. The entry is freed at the next edge.
REQ-032 A fill tag that matches no valid entry SHALL be ignored (wr_en=0).
REQ-033 Simultaneous accept and fill in one cycle: both take effect at the same edge. A freed entry is not reallocatable in the same cycle; the free slot is computed from registered valid bits.
REQ-034 When mshr_full=1, no issue occurs even if a fill frees an entry in the same cycle.
REQ-035 take_branch suppresses issue only. Outstanding entries persist and complete normally.
REQ-036 mshr_count SHALL equal the popcount of valid bits. Its range is 0..MSHR_DEPTH, with no wrap.

Reset
REQ-037 While reset=1, asynchronously: all entries are invalid, mshr_count=0, mshr_full=0, proc2Imem_command=BUS_NONE, proc2Imem_addr=0 and wr_en=0.
REQ-038 Reset during outstanding misses discards them. Later fills carrying those tags are ignored per REQ-032.

Verification
REQ-039 Single miss: way0 miss at 0x1004, response=3 -> BUS_LOAD addr 0x1000 and entry allocated. Tag 3 with data D two cycles later -> wr_en=1, wr_idx=0x00, wr_tag=0x010, wr_data=D, count returns to 0.
REQ-040 Dedup: ways 0 and 1 both miss block 0x1000, held for 3 cycles after acceptance -> exactly one BUS_LOAD issued, mshr_count=1.
REQ-041 Full: four distinct misses accepted with tags 1..4, then a fifth miss -> mshr_full=1, BUS_NONE. Fill tag 2 -> fifth miss issues on the following cycle into entry 1.
REQ-042 Reject/retry: response=0 for two cycles then 5 -> three BUS_LOAD cycles and a single allocation with tag 5.
REQ-043 Branch and stall: take_branch=1 with a miss -> BUS_NONE, with the outstanding fill still written. hit_but_stall=1 with a miss -> BUS_NONE.
REQ-044 Reset mid-flight: two entries outstanding, assert reset -> count=0 immediately. A later fill with an old tag -> wr_en=0.
